// File: rtl/lcd_16x2_ctrl_pkg.sv
// Shared definitions for the 16x2 LCD sequencer: state encoding, HD44780 command
// bytes and the power-up init command list.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_ISSUE,
    INIT_WAIT,
    CLR_WAIT,
    IDLE,
    ADDR1,
    CHAR,
    ADDR2,
    XFER_WAIT
  } state_t;

  localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_LINE1        = 8'h80;
  localparam logic [7:0] CMD_LINE2        = 8'hC0;

  localparam int unsigned INIT_LEN = 5;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_FUNC_8BIT_2L;
      3'd1:    return CMD_FUNC_8BIT_2L;
      3'd2:    return CMD_DISP_ON;
      3'd3:    return CMD_ENTRY_INC;
      3'd4:    return CMD_CLEAR;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_16x2_ctrl_if.sv
// Byte-level handshake between the sequencer and the LCD byte writer.
interface lcd_16x2_ctrl_if;
  logic [7:0] lcd_byte;
  logic       lcd_cd;
  logic       lcd_start;
  logic       lcd_done;

  modport master (output lcd_byte, output lcd_cd, output lcd_start, input lcd_done);
  modport slave  (input lcd_byte, input lcd_cd, input lcd_start, output lcd_done);
endinterface

// File: rtl/lcd_16x2_ctrl_frame_buf.sv
// 32x8 character frame buffer: one synchronous write port, one asynchronous read
// port, all entries reset to ASCII space.
module lcd_frame_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: 8'h20};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_16x2_ctrl.sv
// 16x2 LCD sequencer: power-up delay, HD44780 init list, then 34-byte frame
// streaming (line address + 16 chars per line) through a one-byte writer handshake.
module lcd_16x2_ctrl #(
  parameter int POWER_UP_CYCLES   = 1000000,
  parameter int CLEAR_WAIT_CYCLES = 100000,
  parameter int CNT_W             = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [4:0]             wr_addr,
  input  logic [7:0]             wr_char,
  input  logic                   refresh,
  lcd_16x2_ctrl_if.master        lcd,
  output logic                   ready,
  output logic                   busy
);

  import lcd_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [4:0]       pos_q;
  logic             pending_q;
  logic [7:0]       byte_d;
  logic             cd_d;
  logic             start_d;
  logic [7:0]       rd_char;
  logic             last_init;
  logic             pwr_done;
  logic             clr_done;

  lcd_frame_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_char),
    .raddr (pos_q),
    .rdata (rd_char)
  );

  assign last_init = (idx_q == 3'(INIT_LEN - 1));
  assign pwr_done  = (cnt_q == CNT_W'(POWER_UP_CYCLES - 1));
  assign clr_done  = (cnt_q == CNT_W'(CLEAR_WAIT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PWR_WAIT;
    else      state_q <= state_d;
  end

  // In XFER_WAIT the held lcd_cd tells whether the outstanding byte was an
  // address command (next is a char) or a character (advance pos).
  always_comb begin
    state_d = state_q;
    case (state_q)
      PWR_WAIT:   if (pwr_done) state_d = INIT_ISSUE;
      INIT_ISSUE: state_d = INIT_WAIT;
      INIT_WAIT: begin
        if (lcd.lcd_done) begin
          if (lcd.lcd_byte == CMD_CLEAR) state_d = CLR_WAIT;
          else if (last_init)            state_d = IDLE;
          else                           state_d = INIT_ISSUE;
        end
      end
      CLR_WAIT:   if (clr_done) state_d = last_init ? IDLE : INIT_ISSUE;
      IDLE:       if (refresh || pending_q) state_d = ADDR1;
      ADDR1, CHAR, ADDR2: state_d = XFER_WAIT;
      XFER_WAIT: begin
        if (lcd.lcd_done) begin
          if (!lcd.lcd_cd)           state_d = CHAR;
          else if (pos_q == 5'd31)   state_d = IDLE;
          else if (pos_q == 5'd15)   state_d = ADDR2;
          else                       state_d = CHAR;
        end
      end
      default:    state_d = PWR_WAIT;
    endcase
  end

  always_comb begin
    byte_d  = lcd.lcd_byte;
    cd_d    = lcd.lcd_cd;
    start_d = 1'b0;
    case (state_q)
      INIT_ISSUE: begin byte_d = init_rom(idx_q); cd_d = 1'b0; start_d = 1'b1; end
      ADDR1:      begin byte_d = CMD_LINE1;       cd_d = 1'b0; start_d = 1'b1; end
      CHAR:       begin byte_d = rd_char;         cd_d = 1'b1; start_d = 1'b1; end
      ADDR2:      begin byte_d = CMD_LINE2;       cd_d = 1'b0; start_d = 1'b1; end
      default:    ;
    endcase
    ready = (state_q == IDLE);
    busy  = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pos_q         <= '0;
      pending_q     <= 1'b0;
      lcd.lcd_byte  <= '0;
      lcd.lcd_cd    <= 1'b0;
      lcd.lcd_start <= 1'b0;
    end else begin
      if (state_q == PWR_WAIT || state_q == CLR_WAIT)
        cnt_q <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

      if (state_q == PWR_WAIT)
        idx_q <= '0;
      else if ((state_q == INIT_WAIT || state_q == CLR_WAIT) && state_d == INIT_ISSUE)
        idx_q <= idx_q + 3'd1;

      if (state_q == IDLE)
        pos_q <= '0;
      else if (state_q == XFER_WAIT && lcd.lcd_done && lcd.lcd_cd && state_d != IDLE)
        pos_q <= pos_q + 5'd1;

      if (state_q == IDLE) pending_q <= 1'b0;
      else if (refresh)    pending_q <= 1'b1;

      lcd.lcd_byte  <= byte_d;
      lcd.lcd_cd    <= cd_d;
      lcd.lcd_start <= start_d;
    end
  end

endmodule

// File: tb/tb_lcd_16x2_ctrl.sv
// Bench for lcd_16x2_ctrl: writer model answering done 10 cycles after start,
// expected byte stream kept in a scoreboard queue.
module tb_lcd_16x2_ctrl;

  localparam int PU = 100;
  localparam int CW = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       refresh = 1'b0;
  logic       ready, busy;

  lcd_16x2_ctrl_if lcd ();

  lcd_16x2_ctrl #(
    .POWER_UP_CYCLES   (PU),
    .CLEAR_WAIT_CYCLES (CW),
    .CNT_W             (20)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .refresh (refresh),
    .lcd     (lcd),
    .ready   (ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] q[$];
  logic [7:0] model [32];
  int         cyc = 0;
  int         wcnt = 0;
  logic [8:0] cur = '0;
  int         first_start = -1;
  int         last_done = -1;
  int         n_start = 0;
  int         ready_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Writer model and scoreboard consumer
  always @(negedge clk) begin
    logic [8:0] exp_v;
    if (!rst) begin
      wcnt = 0;
      lcd.lcd_done = 1'b0;
    end else begin
      lcd.lcd_done = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          lcd.lcd_done = 1'b1;
          last_done = cyc;
          checks++;
          if ({lcd.lcd_cd, lcd.lcd_byte} !== cur) begin
            failures++;
            $display("FAIL hold_stable got=%h exp=%h", {lcd.lcd_cd, lcd.lcd_byte}, cur);
          end
        end
      end
      if (lcd.lcd_start === 1'b1) begin
        n_start++;
        if (first_start < 0) first_start = cyc;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte got=%h exp=none", {lcd.lcd_cd, lcd.lcd_byte});
        end else begin
          exp_v = q.pop_front();
          if (wcnt != 0) begin
            failures++;
            $display("FAIL overlap_start got=busy_writer exp=idle_writer");
          end else if ({lcd.lcd_cd, lcd.lcd_byte} !== exp_v) begin
            failures++;
            $display("FAIL byte_stream got=%h exp=%h", {lcd.lcd_cd, lcd.lcd_byte}, exp_v);
          end
        end
        cur  = {lcd.lcd_cd, lcd.lcd_byte};
        wcnt = 10;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_init();
    logic [7:0] il [5];
    il = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    foreach (il[i]) q.push_back({1'b0, il[i]});
  endtask

  task automatic push_frame(input logic [7:0] b [32]);
    q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) q.push_back({1'b1, b[i]});
    q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) q.push_back({1'b1, b[i]});
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    tick();
    wr_en = 1'b0;
    model[a] = c;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic wait_quiet(input int bound, input string name);
    int n = 0;
    while (!(ready === 1'b1 && q.size() == 0) && n < bound) begin
      tick();
      n++;
    end
    ready_cyc = cyc;
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL %s_timeout got=ready:%b queued:%0d exp=ready:1 queued:0", name, ready, q.size());
    end
  endtask

  task automatic wait_starts(input int target, input int bound);
    int n = 0;
    while (n_start < target && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL start_wait_timeout got=%0d exp=%0d", n_start, target);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({lcd.lcd_start, lcd.lcd_cd, lcd.lcd_byte, ready, busy} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL %s got=start:%b cd:%b byte:%h ready:%b busy:%b exp=0 0 00 0 1",
               name, lcd.lcd_start, lcd.lcd_cd, lcd.lcd_byte, ready, busy);
    end
  endtask

  task automatic release_and_init(input string name);
    int rel;
    first_start = -1;
    push_init();
    rst = 1'b1;
    rel = cyc;
    wait_quiet(1000, name);
    checks++;
    if (first_start - rel < PU || first_start - rel > PU + 5) begin
      failures++;
      $display("FAIL %s_powerup_delay got=%0d exp=%0d..%0d", name, first_start - rel, PU, PU + 5);
    end
    checks++;
    if (ready_cyc - last_done < CW || ready_cyc - last_done > CW + 5) begin
      failures++;
      $display("FAIL %s_clear_gap got=%0d exp=%0d..%0d", name, ready_cyc - last_done, CW, CW + 5);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy got=%b exp=0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_values");
    q.delete();
    foreach (model[i]) model[i] = 8'h20;
    release_and_init("init");
  endtask

  task automatic test_frame();
    int n0;
    logic [7:0] h [5];
    logic [7:0] w [5];
    h = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    w = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
    for (int i = 0; i < 5; i++) write_char(5'(i), h[i]);
    for (int i = 0; i < 5; i++) write_char(5'(16 + i), w[i]);
    push_frame(model);
    n0 = n_start;
    pulse_refresh();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL frame_ready_low got=%b exp=0", ready);
    end
    wait_quiet(2000, "frame");
    repeat (30) tick();
    checks++;
    if (n_start - n0 != 34) begin
      failures++;
      $display("FAIL frame_byte_count got=%0d exp=34", n_start - n0);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = n_start;
    push_frame(model);
    pulse_refresh();
    repeat (60) tick();
    for (int i = 0; i < 3; i++) begin
      pulse_refresh();
      repeat (7) tick();
    end
    push_frame(model);
    wait_quiet(3000, "multi_refresh");
    repeat (40) tick();
    checks++;
    if (n_start - n0 != 68) begin
      failures++;
      $display("FAIL multi_refresh_count got=%0d exp=68", n_start - n0);
    end
  endtask

  task automatic test_refresh_pwr();
    int n0;
    rst = 1'b0;
    repeat (2) tick();
    q.delete();
    foreach (model[i]) model[i] = 8'h20;
    push_init();
    push_frame(model);
    first_start = -1;
    n0 = n_start;
    rst = 1'b1;
    repeat (20) tick();
    pulse_refresh();
    wait_quiet(3000, "refresh_pwr");
    repeat (30) tick();
    checks++;
    if (n_start - n0 != 39) begin
      failures++;
      $display("FAIL refresh_pwr_count got=%0d exp=39", n_start - n0);
    end
  endtask

  task automatic test_write_midframe();
    logic [7:0] tmp [32];
    int n0;
    tmp = model;
    tmp[31] = 8'h41;
    push_frame(tmp);
    n0 = n_start;
    pulse_refresh();
    wait_starts(n0 + 3, 200);
    write_char(5'd31, 8'h41);
    write_char(5'd0, 8'h42);
    wait_quiet(2000, "write_midframe");
    push_frame(model);
    pulse_refresh();
    wait_quiet(2000, "write_followup");
  endtask

  task automatic test_reset_midframe();
    int n0 = n_start;
    push_frame(model);
    pulse_refresh();
    wait_starts(n0 + 10, 400);
    rst = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    q.delete();
    foreach (model[i]) model[i] = 8'h20;
    repeat (2) tick();
    check_reset_outputs("midframe_reset_held");
    release_and_init("reinit");
    push_frame(model);
    pulse_refresh();
    wait_quiet(2000, "cleared_frame");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_refresh_pwr();
    test_write_midframe();
    test_reset_midframe();
    repeat (20) tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_16x2_ctrl.md
Name: lcd_16x2_ctrl

Overview:
Upstream sequencer for the 16x2 LCD byte writer (8-bit bus; ports data/cd/start in, done_tick out). It runs the power-up delay and the HD44780 init command list. It then streams a 32-character frame buffer to the display as line-address commands plus character bytes, issuing one byte per writer handshake. The host side writes characters into the buffer and requests refreshes; all LCD timing below byte level stays in the writer.

Parameters:
POWER_UP_CYCLES, 1000000, idle cycles after reset before the first command (20 ms at 50 MHz)
CLEAR_WAIT_CYCLES, 100000, extra wait after the clear command 0x01 (2 ms at 50 MHz)
CNT_W, 20, width of the delay counter; must hold max(POWER_UP_CYCLES, CLEAR_WAIT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  5  buffer index; 0-15 is line 1, 16-31 is line 2
wr_char  in  8  ASCII code to store
refresh  in  1  single-cycle frame refresh request
lcd_byte  out  8  byte to writer data input
lcd_cd  out  1  to writer cd; 0 = command, 1 = character
lcd_start  out  1  to writer start; single-cycle pulse
lcd_done  in  1  from writer done_tick
ready  out  1  high when init is complete and no frame is in progress
busy  out  1  high while init or a frame transfer is active

Behaviour:
- Reset, asynchronous and active-low: state=PWR_WAIT, counter=0, lcd_byte=0x00, lcd_cd=0, lcd_start=0, ready=0, busy=1, pending=0. Buffer contents are set to 0x20 (space).
- Buffer write: on any cycle with wr_en, buf[wr_addr] <= wr_char. This works in every state, including mid-frame. A character is read when its byte is issued, so a write lands in the current frame only if its index has not yet been sent.
- Handshake: lcd_start is high for exactly one cycle. lcd_byte and lcd_cd are updated on the same edge that raises lcd_start and held stable until lcd_done is seen. The next lcd_start rises no earlier than the cycle after lcd_done. Only one byte is outstanding at a time.
- States:
  - PWR_WAIT: count to POWER_UP_CYCLES-1, then go to INIT_ISSUE with init index = 0.
  - INIT_ISSUE: send INIT_ROM[idx] with cd=0, pulse start, then go to INIT_WAIT.
  - INIT_WAIT: on lcd_done, if the byte just sent was 0x01, go to CLR_WAIT. Otherwise go to the next index, or to IDLE after the last entry.
  - CLR_WAIT: count CLEAR_WAIT_CYCLES, then continue the init list.
  - INIT_ROM order is 0x38, 0x38, 0x0C, 0x06, 0x01.
  - IDLE: ready=1, busy=0. If refresh or pending is set, clear pending, set pos=0, and go to ADDR1.
  - ADDR1: send 0x80 with cd=0, then go to XFER_WAIT.
  - CHAR: send buf[pos] with cd=1, then go to XFER_WAIT.
  - ADDR2: send 0xC0 with cd=0, then go to XFER_WAIT.
  - XFER_WAIT: on lcd_done, follow the frame order in the next bullet.
- Frame order: 0x80, buf[0..15], 0xC0, buf[16..31], which is 34 bytes. After the byte for pos 15, go to ADDR2; after pos 31, go to IDLE. pos is 5 bits and never wraps inside a frame.
- A refresh arriving while busy (init or frame) sets pending. Multiple refreshes collapse into one. Pending is serviced from IDLE on the cycle after entering IDLE.
- A refresh during init is held pending. The first frame starts immediately after init completes.
- lcd_done in any state other than INIT_WAIT or XFER_WAIT is ignored.
- Reset mid-transfer aborts immediately; the sequence restarts from PWR_WAIT.
- There is no timeout on lcd_done.

Decomposition:
- Package lcd_pkg holds:
  - state encoding, a 4-bit enum for the 9 states
  - command constants CMD_FUNC_8BIT_2L=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY_INC=0x06, CMD_CLEAR=0x01, CMD_LINE1=0x80, CMD_LINE2=0xC0
  - INIT_LEN=5
- One sub-module is natural: lcd_frame_buf, a 32x8 register file with one write port, one asynchronous read port, and reset to 0x20.
- The init ROM and sequencer stay in the top module.

Test Plan:
- Sim uses POWER_UP_CYCLES=100 and CLEAR_WAIT_CYCLES=50, with a writer model that returns done 10 cycles after start.
- Reset release: no lcd_start for 100 cycles. The bench then sees bytes 0x38, 0x38, 0x0C, 0x06, 0x01 with cd=0. A gap of at least 50 cycles follows the 0x01 done, then ready=1.
- Write "HELLO" to addr 0-4 and "WORLD" to addr 16-20, then pulse refresh. Expect 34 bytes: 0x80, 48 45 4C 4C 4F, eleven 0x20, 0xC0, 57 4F 52 4C 44, eleven 0x20. cd matches byte type, and ready returns after the last done.
- Pulse refresh 3 times mid-frame: exactly one more frame follows the current one.
- Pulse refresh during PWR_WAIT: the frame starts right after the init sequence with no extra pulse.
- Write addr 31 = 0x41 while pos=2 and addr 0 = 0x42 at the same time: the current frame sends 0x41 at the last char but keeps the old addr 0 value.
- Assert rst mid-frame: outputs return to reset values immediately, and the full init replays after release.
